// File: rtl/ttc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ttc_sequencer                                                |
// | Description : TTC command sequencer. Serialises trigger/BCR/ER/MR frames   |
// |               onto a 2-bit symbol stream. Optional PERIODIC_BCR_EN adds an |
// |               orbit counter that issues BCR every ORBIT_LEN cycles.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ttc_sequencer #(
  parameter int TRIG_DEPTH = 8,
  parameter int GAP_CYCLES = 1,
  parameter int ORBIT_LEN  = 3564
) (
  input  logic                          clk_40,
  input  logic                          rst_40,
  input  logic                          trigger,
  input  logic                          bc_reset,
  input  logic                          event_reset,
  input  logic                          master_reset,
  input  logic                          clr_overflow,
  output logic [1:0]                    encode_ttc,
  output logic                          fpga_bcr,
  output logic                          busy,
  output logic [$clog2(TRIG_DEPTH):0]   trig_pending,
  output logic                          trig_overflow
);

  localparam int              c_cw       = $clog2(TRIG_DEPTH) + 1;
  localparam logic [c_cw-1:0] c_depth    = c_cw'(TRIG_DEPTH);
  localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
  localparam logic            c_has_gap  = (GAP_CYCLES > 0);
  localparam logic [2:0]      c_gap_last = (GAP_CYCLES > 0) ? 3'(GAP_CYCLES - 1) : 3'd0;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_send = 2'd1;
  localparam logic [1:0] c_st_gap  = 2'd2;

  localparam logic [1:0] c_fr_trg = 2'd0;
  localparam logic [1:0] c_fr_bcr = 2'd1;
  localparam logic [1:0] c_fr_er  = 2'd2;
  localparam logic [1:0] c_fr_mr  = 2'd3;

  // Request bit order: [0] trigger, [1] bc_reset, [2] event_reset, [3] master_reset
  logic [3:0]      r_req_q;
  logic [3:0]      r_req_d;
  logic [3:0]      w_pulse;
  logic            r_boot;
  logic            r_bcr_flag;
  logic            r_er_flag;
  logic            r_mr_flag;
  logic [c_cw-1:0] r_trig_cnt;
  logic            r_overflow;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nx;
  logic [1:0]      r_frame;
  logic [2:0]      r_cnt;
  logic [1:0]      w_sel;
  logic            w_orbit_req;
  logic            w_bcr_pend;
  logic            w_any;
  logic            w_send_last;
  logic            w_gap_last;
  logic            w_launch;
  logic            w_trg_in;
  logic            w_trg_out;
  logic            w_drop;

  assign w_pulse = r_req_q & ~r_req_d;

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      r_req_q <= 4'd0;
      r_req_d <= 4'd0;
      r_boot  <= 1'b1;
    end else begin
      r_req_q <= {master_reset, event_reset, bc_reset, trigger};
      r_req_d <= r_req_q;
      r_boot  <= 1'b0;
    end
  end

`ifdef PERIODIC_BCR_EN
  localparam int             c_ow         = (ORBIT_LEN > 2) ? $clog2(ORBIT_LEN) : 1;
  localparam logic [c_ow-1:0] c_orbit_last = c_ow'(ORBIT_LEN - 1);

  logic [c_ow-1:0] r_orbit;

  assign w_orbit_req = (r_orbit == c_orbit_last);

  // Sending any BCR realigns the orbit so the next periodic BCR is ORBIT_LEN later
  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      r_orbit <= '0;
    end else if ((w_launch && (w_sel == c_fr_bcr)) || w_orbit_req) begin
      r_orbit <= '0;
    end else begin
      r_orbit <= r_orbit + c_ow'(1);
    end
  end
`else
  // ORBIT_LEN has no effect without the orbit counter
  assign w_orbit_req = (ORBIT_LEN < 0);
`endif

  assign w_bcr_pend  = r_bcr_flag | w_orbit_req;
  assign w_any       = w_bcr_pend | r_mr_flag | r_er_flag | (r_trig_cnt != '0);
  assign w_send_last = (r_state == c_st_send) && (r_cnt == 3'd2);
  assign w_gap_last  = (r_state == c_st_gap) && (r_cnt == c_gap_last);
  // A new frame may start from IDLE, straight after the final gap symbol, or
  // straight after the third symbol when there is no gap
  assign w_launch    = w_any & ((r_state == c_st_idle) | w_gap_last |
                                (w_send_last & ~c_has_gap));

  always_comb begin
    w_sel = c_fr_trg;
    if (w_bcr_pend) begin
      w_sel = c_fr_bcr;
    end else if (r_mr_flag) begin
      w_sel = c_fr_mr;
    end else if (r_er_flag) begin
      w_sel = c_fr_er;
    end
  end

  assign w_trg_in  = w_pulse[0];
  assign w_trg_out = w_launch && (w_sel == c_fr_trg);
  assign w_drop    = w_trg_in && !w_trg_out && (r_trig_cnt == c_depth);

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      r_bcr_flag <= 1'b0;
      r_er_flag  <= 1'b0;
      r_mr_flag  <= 1'b0;
      r_trig_cnt <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_bcr_flag <= (r_bcr_flag | w_pulse[1] | r_boot | w_orbit_req) &
                    ~(w_launch && (w_sel == c_fr_bcr));
      r_er_flag  <= (r_er_flag | w_pulse[2] | r_boot) &
                    ~(w_launch && (w_sel == c_fr_er));
      r_mr_flag  <= (r_mr_flag | w_pulse[3]) &
                    ~(w_launch && (w_sel == c_fr_mr));
      if (w_trg_in && !w_trg_out && (r_trig_cnt != c_depth)) begin
        r_trig_cnt <= r_trig_cnt + c_cnt_one;
      end else if (!w_trg_in && w_trg_out) begin
        r_trig_cnt <= r_trig_cnt - c_cnt_one;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_st_idle: if (w_any) w_state_nx = c_st_send;
      c_st_send: begin
        if (w_send_last) begin
          if (c_has_gap) w_state_nx = c_st_gap;
          else           w_state_nx = w_any ? c_st_send : c_st_idle;
        end
      end
      c_st_gap:  if (w_gap_last) w_state_nx = w_any ? c_st_send : c_st_idle;
      default:   w_state_nx = c_st_idle;
    endcase
  end

  always_ff @(posedge clk_40 or posedge rst_40) begin
    if (rst_40) begin
      r_cnt   <= 3'd0;
      r_frame <= c_fr_trg;
    end else begin
      if (w_launch) begin
        r_cnt   <= 3'd0;
        r_frame <= w_sel;
      end else if (r_state == c_st_send) begin
        r_cnt <= w_send_last ? 3'd0 : r_cnt + 3'd1;
      end else if (r_state == c_st_gap) begin
        r_cnt <= r_cnt + 3'd1;
      end else begin
        r_cnt <= 3'd0;
      end
    end
  end

  always_comb begin
    encode_ttc = 2'b00;
    fpga_bcr   = 1'b0;
    busy       = (r_state != c_st_idle);
    if (r_state == c_st_send) begin
      case (r_frame)
        c_fr_trg: encode_ttc = (r_cnt == 3'd0) ? 2'b11 : 2'b00;
        c_fr_bcr: encode_ttc = (r_cnt != 3'd2) ? 2'b11 : 2'b00;
        c_fr_er:  encode_ttc = 2'b11;
        default:  encode_ttc = (r_cnt != 3'd1) ? 2'b11 : 2'b00;
      endcase
      fpga_bcr = (r_frame == c_fr_bcr) && (r_cnt == 3'd0);
    end
  end

  assign trig_pending  = r_trig_cnt;
  assign trig_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ttc_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// Testbench for ttc_sequencer: per-cycle vector table plus directed
// overflow, reset-abort and (with PERIODIC_BCR_EN) orbit sequences.
module tb_ttc_sequencer;

  logic       clk_40 = 1'b0;
  logic       rst_40;
  logic       trigger, bc_reset, event_reset, master_reset, clr_overflow;
  logic [1:0] encode_ttc;
  logic       fpga_bcr, busy, trig_overflow;
  logic [3:0] trig_pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #12 clk_40 = ~clk_40;

  ttc_sequencer #(.TRIG_DEPTH(8), .GAP_CYCLES(1), .ORBIT_LEN(3564)) dut (
    .clk_40(clk_40), .rst_40(rst_40), .trigger(trigger), .bc_reset(bc_reset),
    .event_reset(event_reset), .master_reset(master_reset),
    .clr_overflow(clr_overflow), .encode_ttc(encode_ttc), .fpga_bcr(fpga_bcr),
    .busy(busy), .trig_pending(trig_pending), .trig_overflow(trig_overflow)
  );

`ifdef PERIODIC_BCR_EN
  logic       p_zero = 1'b0;
  logic [1:0] p_enc;
  logic       p_fb, p_busy, p_ovf;
  logic [3:0] p_pend;
  ttc_sequencer #(.TRIG_DEPTH(8), .GAP_CYCLES(1), .ORBIT_LEN(16)) dut_orbit (
    .clk_40(clk_40), .rst_40(rst_40), .trigger(p_zero), .bc_reset(p_zero),
    .event_reset(p_zero), .master_reset(p_zero), .clr_overflow(p_zero),
    .encode_ttc(p_enc), .fpga_bcr(p_fb), .busy(p_busy),
    .trig_pending(p_pend), .trig_overflow(p_ovf)
  );
`endif

  typedef struct {
    logic [4:0] in;   // {trigger, bc_reset, event_reset, master_reset, clr_overflow}
    logic [1:0] enc;
    logic       fb;
    logic       bsy;
    logic [3:0] pend;
    logic       ovf;
  } vec_t;

  vec_t vt[36];

  function automatic vec_t mk(input logic [4:0] in, input logic [1:0] enc,
                              input logic fb, input logic bsy, input logic [3:0] pend);
    vec_t v;
    v.in = in; v.enc = enc; v.fb = fb; v.bsy = bsy; v.pend = pend; v.ovf = 1'b0;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_40);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {23'd0, encode_ttc, fpga_bcr, busy, trig_pending, trig_overflow};
  endfunction

  // Classifies frames on the symbol stream; a frame starts on 11 after a 00
  task automatic watch(input int ncyc, output int n_trg, output int n_bcr,
                       output int n_er, output int n_mr, output int n_fb,
                       output int first);
    logic [1:0] prev, s1;
    int pos;
    n_trg = 0; n_bcr = 0; n_er = 0; n_mr = 0; n_fb = 0; first = -1;
    prev = encode_ttc; s1 = 2'b00; pos = 0;
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (fpga_bcr) n_fb++;
      if (pos == 0) begin
        if (encode_ttc == 2'b11 && prev == 2'b00) pos = 1;
      end else if (pos == 1) begin
        s1 = encode_ttc;
        pos = 2;
      end else begin
        case ({s1, encode_ttc})
          4'b0000: begin n_trg++; if (first < 0) first = 0; end
          4'b1100: begin n_bcr++; if (first < 0) first = 1; end
          4'b1111: begin n_er++;  if (first < 0) first = 2; end
          4'b0011: begin n_mr++;  if (first < 0) first = 3; end
          default: ;
        endcase
        pos = 0;
      end
      prev = encode_ttc;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nt, nb, ne, nm, nf, fst;

    vt[0]  = mk(5'b00000, 2'b00, 0, 0, 0);
    vt[1]  = mk(5'b00000, 2'b11, 1, 1, 0);
    vt[2]  = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[3]  = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[4]  = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[5]  = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[6]  = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[7]  = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[8]  = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[9]  = mk(5'b00000, 2'b00, 0, 0, 0);
    vt[10] = mk(5'b10000, 2'b00, 0, 0, 0);
    vt[11] = mk(5'b00000, 2'b00, 0, 0, 1);
    vt[12] = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[13] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[14] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[15] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[16] = mk(5'b00000, 2'b00, 0, 0, 0);
    vt[17] = mk(5'b11110, 2'b00, 0, 0, 0);
    vt[18] = mk(5'b00000, 2'b00, 0, 0, 1);
    vt[19] = mk(5'b00000, 2'b11, 1, 1, 1);
    vt[20] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[21] = mk(5'b00000, 2'b00, 0, 1, 1);
    vt[22] = mk(5'b00000, 2'b00, 0, 1, 1);
    vt[23] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[24] = mk(5'b00000, 2'b00, 0, 1, 1);
    vt[25] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[26] = mk(5'b00000, 2'b00, 0, 1, 1);
    vt[27] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[28] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[29] = mk(5'b00000, 2'b11, 0, 1, 1);
    vt[30] = mk(5'b00000, 2'b00, 0, 1, 1);
    vt[31] = mk(5'b00000, 2'b11, 0, 1, 0);
    vt[32] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[33] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[34] = mk(5'b00000, 2'b00, 0, 1, 0);
    vt[35] = mk(5'b00000, 2'b00, 0, 0, 0);

    rst_40 = 1'b1;
    {trigger, bc_reset, event_reset, master_reset, clr_overflow} = 5'b00000;
    step();
    step();
    check("reset_state", 0, outs(), 32'd0);
    rst_40 = 1'b0;

    // Boot BCR/ER, single trigger, then all four requests in one cycle
    for (int i = 0; i < 36; i++) begin
      {trigger, bc_reset, event_reset, master_reset, clr_overflow} = vt[i].in;
      step();
      check("vector", i, outs(),
            {23'd0, vt[i].enc, vt[i].fb, vt[i].bsy, vt[i].pend, vt[i].ovf});
    end

    // Trigger burst held back by repeated BCRs; clr_overflow on the final drop
    for (int i = 0; i < 10; i++) begin
      trigger = 1'b1; bc_reset = 1'b1;
      step();
      trigger = 1'b0; bc_reset = 1'b0;
      if (i == 9) clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
    end
    step();
    check("sat_pending", 0, {28'd0, trig_pending}, 32'd8);
    check("ovf_set_wins", 0, {31'd0, trig_overflow}, 32'd1);
    watch(60, nt, nb, ne, nm, nf, fst);
    check("drain_trig_frames", 0, nt, 8);
    check("drain_pending", 0, {28'd0, trig_pending}, 32'd0);
    check("ovf_sticky", 0, {31'd0, trig_overflow}, 32'd1);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    check("ovf_cleared", 0, {31'd0, trig_overflow}, 32'd0);

    // Reset on the second symbol of an MR frame, with a trigger queued
    master_reset = 1'b1; trigger = 1'b1;
    step();
    master_reset = 1'b0; trigger = 1'b0;
    step();
    step();
    check("mr_sym0", 0, {30'd0, encode_ttc}, 32'd3);
    step();
    check("mr_sym1_busy_pend", 0, {27'd0, busy, trig_pending}, {27'd0, 1'b1, 4'd1});
    rst_40 = 1'b1;
    #1;
    check("async_reset", 0, outs(), 32'd0);
    step();
    step();
    rst_40 = 1'b0;
    watch(30, nt, nb, ne, nm, nf, fst);
    check("post_rst_bcr", 0, nb, 1);
    check("post_rst_er", 0, ne, 1);
    check("post_rst_other", 0, nt + nm, 0);
    check("post_rst_first_bcr", 0, fst, 1);
    check("post_rst_fpga_bcr", 0, nf, 1);

`ifdef PERIODIC_BCR_EN
    begin
      int last, npulse;
      last = -1; npulse = 0;
      for (int i = 0; i < 90; i++) begin
        step();
        if (p_fb) begin
          if (last >= 0) check("orbit_period", npulse, i - last, 16);
          last = i;
          npulse++;
        end
      end
      check("orbit_pulses", 0, (npulse >= 5) ? 1 : 0, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
